// File: rtl/led_pkg.sv
// Shared mode codes, direction type and initial LED patterns for the LED pattern scheduler.
package led_pkg;

  localparam int unsigned LED_W  = 8;
  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 3'd0,
    MODE_RUN_L  = 3'd1,
    MODE_RUN_R  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_BLINK  = 3'd4,
    MODE_FILL   = 3'd5
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [LED_W-1:0] INIT_OFF   = 8'h00;
  localparam logic [LED_W-1:0] INIT_RUN_L = 8'h01;
  localparam logic [LED_W-1:0] INIT_RUN_R = 8'h80;
  localparam logic [LED_W-1:0] INIT_BLINK = 8'hFF;

  // Codes 6 and 7 have no pattern behind them.
  function automatic logic mode_illegal(input logic [MODE_W-1:0] code);
    return code > 3'd5;
  endfunction

  function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
    logic [LED_W-1:0] p;
    case (m)
      MODE_OFF:    p = INIT_OFF;
      MODE_RUN_L:  p = INIT_RUN_L;
      MODE_RUN_R:  p = INIT_RUN_R;
      MODE_BOUNCE: p = INIT_RUN_L;
      MODE_BLINK:  p = INIT_BLINK;
      MODE_FILL:   p = INIT_RUN_L;
      default:     p = INIT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: one step_tick every TICK_DIV unpaused cycles.
module tick_prescaler #(
  parameter  int unsigned TICK_DIV = 25000,
  localparam int unsigned CW       = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  output logic step_tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign step_tick = (cnt == CNT_LAST) && !pause;

endmodule

// File: rtl/led_pattern_sched.sv
// LED bank pattern sequencer; mode changes are queued by handshake and applied on a step tick.
module led_pattern_sched
  import led_pkg::*;
#(
  parameter int unsigned       TICK_DIV = 25000,
  parameter logic [MODE_W-1:0] RST_MODE = 3'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [MODE_W-1:0] cmd_mode,
  output logic              cmd_ready,
  output logic              cmd_err,
  input  logic              pause,
  output logic              step_tick,
  output logic [MODE_W-1:0] mode_cur,
  output logic [LED_W-1:0]  led
);

  mode_t            mode_q;
  mode_t            pend_mode;
  logic             pending;
  dir_t             dir;
  logic [LED_W-1:0] led_nxt;
  dir_t             dir_nxt;
  logic             accept;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .pause     (pause),
    .step_tick (step_tick)
  );

  assign accept   = cmd_valid && cmd_ready;
  assign mode_cur = mode_q;

  // Next pattern for a normal step in the current mode.
  always_comb begin
    led_nxt = led;
    dir_nxt = dir;
    case (mode_q)
      MODE_OFF:   led_nxt = INIT_OFF;
      MODE_RUN_L: led_nxt = {led[6:0], led[7]};
      MODE_RUN_R: led_nxt = {led[0], led[7:1]};
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          led_nxt = {led[6:0], 1'b0};
          if (led_nxt == 8'h80) dir_nxt = DIR_RIGHT;
        end else begin
          led_nxt = {1'b0, led[7:1]};
          if (led_nxt == 8'h01) dir_nxt = DIR_LEFT;
        end
      end
      MODE_BLINK: led_nxt = ~led;
      MODE_FILL:  led_nxt = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
      default:    led_nxt = INIT_OFF;
    endcase
  end

  // A tick either applies the queued mode or steps; acceptance after the tick
  // decision means a command taken on a tick cycle waits for the next tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= mode_t'(RST_MODE);
      pend_mode <= mode_t'(RST_MODE);
      pending   <= 1'b0;
      cmd_ready <= 1'b1;
      cmd_err   <= 1'b0;
      dir       <= DIR_LEFT;
      led       <= init_pattern(mode_t'(RST_MODE));
    end else begin
      cmd_err <= 1'b0;
      if (step_tick) begin
        if (pending) begin
          mode_q    <= pend_mode;
          led       <= init_pattern(pend_mode);
          dir       <= DIR_LEFT;
          pending   <= 1'b0;
          cmd_ready <= 1'b1;
        end else begin
          led <= led_nxt;
          dir <= dir_nxt;
        end
      end
      if (accept) begin
        if (mode_illegal(cmd_mode)) begin
          cmd_err <= 1'b1;
        end else begin
          pend_mode <= mode_t'(cmd_mode);
          pending   <= 1'b1;
          cmd_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Randomized and directed bench for led_pattern_sched against a step-index reference model.
module tb_led_pattern_sched;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_mode = 3'd0;
  logic       cmd_ready;
  logic       cmd_err;
  logic       pause = 1'b0;
  logic       step_tick;
  logic [2:0] mode_cur;
  logic [7:0] led;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: prescaler phase, displayed mode, steps since mode load.
  int m_cnt, m_mode, m_k, m_pmode;
  bit m_pend, m_err;

  always #5 clk = ~clk;

  led_pattern_sched #(.TICK_DIV(TICK_DIV), .RST_MODE(3'd1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cmd_ready (cmd_ready),
    .cmd_err   (cmd_err),
    .pause     (pause),
    .step_tick (step_tick),
    .mode_cur  (mode_cur),
    .led       (led)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pattern shown k steps after a mode was loaded.
  function automatic logic [7:0] exp_led(input int mode, input int k);
    int p;
    case (mode)
      1: return 8'(1 << (k % 8));
      2: return 8'(128 >> (k % 8));
      3: begin
        p = k % 14;
        return 8'(1 << ((p <= 7) ? p : 14 - p));
      end
      4: return (k % 2 == 0) ? 8'hFF : 8'h00;
      5: begin
        p = k % 9;
        return (p == 8) ? 8'h00 : 8'((1 << (p + 1)) - 1);
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = 1; m_k = 0; m_pend = 0; m_pmode = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; pause = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs at negedge, compare, then advance the model over the posedge.
  task automatic cycle(input bit v, input int md, input bit p);
    bit tick, acc;
    cmd_valid = v; cmd_mode = 3'(md); pause = p;
    #1;
    tick = (m_cnt == TICK_DIV - 1) && !p;
    check_eq("step_tick", 32'(step_tick), 32'(tick));
    check_eq("led",       32'(led),       32'(exp_led(m_mode, m_k)));
    check_eq("mode_cur",  32'(mode_cur),  32'(m_mode));
    check_eq("cmd_ready", 32'(cmd_ready), 32'(!m_pend));
    check_eq("cmd_err",   32'(cmd_err),   32'(m_err));
    acc = v && !m_pend;
    m_err = acc && (md > 5);
    if (tick) begin
      if (m_pend) begin
        m_mode = m_pmode; m_k = 0; m_pend = 0;
      end else begin
        m_k++;
      end
    end
    if (acc && md <= 5) begin
      m_pend = 1; m_pmode = md;
    end
    if (!p) m_cnt = (m_cnt + 1) % TICK_DIV;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic idle_until_phase(input int want);
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      if (m_cnt == want) break;
      cycle(0, 0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    bit p_run;
    do_reset();
    #1;
    check_eq("rst_led", 32'(led), 32'h01);
    check_eq("rst_ready", 32'(cmd_ready), 32'h1);
    check_eq("rst_mode", 32'(mode_cur), 32'h1);
    @(negedge clk);
    model_reset();
    m_cnt = 1;
    idle(40);

    // Bounce requested mid-interval.
    idle_until_phase(1);
    cycle(1, 3, 0);
    check_eq("ready_drop", 32'(cmd_ready), 32'h0);
    idle(40);

    // Illegal code.
    cycle(1, 6, 0);
    check_eq("err_pulse", 32'(cmd_err), 32'h1);
    check_eq("err_ready", 32'(cmd_ready), 32'h1);
    idle(5);

    // Command on the tick cycle.
    idle_until_phase(TICK_DIV - 1);
    cycle(1, 4, 0);
    idle(12);

    // Fill, then a long pause with a command accepted inside it.
    cycle(1, 5, 0);
    idle(44);
    for (int i = 0; i < 20; i++) cycle(i == 10, 2, 1);
    idle(12);

    // Reset discards a queued command.
    cycle(1, 2, 0);
    idle(1);
    do_reset();
    idle(40);

    // Random traffic with occasional pause bursts and resets.
    p_run = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) p_run = !p_run;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 7)), p_run);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_sched.md
Name: led_pattern_sched

Overview:
- Controller and scheduler for the 8-bit LED bank: it generates the step tick and sequences one of several display patterns onto `led`.
- Accepts mode-change commands from a requester (button decoder or host register) over a valid/ready handshake.
- Mode changes are applied only on a step-tick boundary, so the display never glitches mid-step.
- Sits between the user-input logic and the board LED pins and replaces free-running shift logic.

Parameters:
- TICK_DIV, 25000, clock cycles per pattern step; must be ≥2; the counter width is $clog2(TICK_DIV).
- RST_MODE, 3'd1, mode loaded at reset (RUN_LEFT).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  mode-change request valid
- cmd_mode  in  3  requested mode code
- cmd_ready  out  1  block can accept a command
- cmd_err  out  1  one-cycle pulse when an illegal mode code is accepted
- pause  in  1  freeze prescaler and pattern while high
- step_tick  out  1  high in the cycle the pattern steps
- mode_cur  out  3  mode currently displayed
- led  out  8  LED drive, bit 0 = rightmost

Behaviour:
- Reset (rst=1 at a clk edge):
  - prescaler cnt=0, pending flag=0, mode_cur=RST_MODE.
  - led = initial pattern of RST_MODE (0x01 for the default).
  - cmd_ready=1, cmd_err=0, bounce dir=left.
  - Reset mid-operation discards any pending command.
- Prescaler:
  - If pause=0: cnt increments and wraps from TICK_DIV-1 to 0.
  - If pause=1: cnt holds.
  - step_tick = (cnt==TICK_DIV-1) & !pause. It is combinational from registered cnt.
- Mode codes and patterns (initial value, then the next value on each tick):
  - 0 OFF: 0x00, held.
  - 1 RUN_LEFT: 0x01, rotate left {led[6:0],led[7]}, so 0x80 goes to 0x01.
  - 2 RUN_RIGHT: 0x80, rotate right {led[0],led[7:1]}.
  - 3 BOUNCE: 0x01 with dir=left. Shift in the current direction. On reaching 0x80, dir flips to right; on reaching 0x01, dir flips to left. Sequence: 01,02,…,80,40,…,01,02.
  - 4 BLINK: 0xFF, then ~led each tick (FF,00,FF…).
  - 5 FILL: 0x01, then {led[6:0],1'b1} until 0xFF. FF goes to 00, and 00 goes to 01.
  - 6,7: illegal.
- Handshake:
  - Acceptance happens when cmd_valid & cmd_ready at the edge.
  - Legal code: the code is stored in pend_mode, pending is set, and cmd_ready goes 0 from the next cycle.
  - Illegal code: not stored; cmd_err=1 for exactly the next cycle; cmd_ready stays 1; display unaffected.
  - cmd_ready = !pending, registered.
- Apply:
  - On the first step_tick while pending=1: mode_cur<=pend_mode, led<=initial pattern of pend_mode instead of a step, dir<=left, pending<=0.
  - cmd_ready returns to 1 in the following cycle.
- Simultaneous events:
  - Acceptance in the same cycle as step_tick: the command applies on the next tick, not this one.
  - A command equal to mode_cur still reloads the initial pattern.
- pause:
  - led, dir, mode_cur and pending all hold.
  - Commands are still accepted while cmd_ready=1.
- Latency:
  - Command to displayed change: between 1 and TICK_DIV cycles plus 1, with pause excluded.
  - Tick to led update: 1 cycle (registered).
- All outputs except step_tick are registered.

Decomposition:
- Shared package led_pkg:
  - mode enum MODE_OFF…MODE_FILL (3-bit) and the illegal-code check function.
  - Initial-pattern constants (INIT_RUN_L=8'h01, INIT_RUN_R=8'h80, INIT_BLINK=8'hFF).
- Sub-module: tick_prescaler (cnt, pause, step_tick, parameter TICK_DIV), reusable by other timed blocks.
- Pattern next-state logic stays in led_pattern_sched as a case on mode_cur.

Test Plan (TICK_DIV=4):
1. Reset then idle 40 cycles: led steps 01,02,04,…,80,01 every 4 cycles. step_tick is periodic with period 4. mode_cur=1.
2. Send cmd_mode=3 mid-interval: cmd_ready drops the next cycle. At the next tick led=0x01 and mode_cur=3. The following ticks give 02,04,…,80,40. cmd_ready returns 1 the cycle after apply.
3. Send cmd_mode=6: cmd_err is high exactly 1 cycle, cmd_ready stays 1, led and mode_cur are unchanged.
4. Assert cmd_valid with cmd_mode=4 on the step_tick cycle: the current tick performs a normal step. At the next tick led=0xFF, then 00, FF alternating.
5. Mode 5 for 10 ticks gives 01,03,07,0F,1F,3F,7F,FF,00,01. Then pause for 20 cycles: led, cnt and step_tick are frozen; a command accepted during pause applies only after pause drops.
6. Assert rst while pending=1 with mode 2 queued: on the next cycle led=0x01, mode_cur=1, cmd_ready=1, and the queued mode is never applied.
